// File: rtl/divider.sv
// Sequential 32-bit signed divider: restoring radix-2, one quotient bit per clock, start/done handshake.
// Optional macro DIVIDER_DIV0_FAST_EN makes divide-by-zero finish one clock after start.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        div0
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state;
  logic [31:0] quo;      // dividend magnitude, shifted out as quotient bits shift in
  logic [31:0] dvs;
  logic [31:0] raw_a;
  logic [32:0] rem;
  logic [4:0]  cnt;
  logic        sq;
  logic        sr;
  logic        bz;

  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [32:0] rem_sh;
  logic [32:0] trial;

  // The magnitude of 0x80000000 wraps back to 0x80000000, which is exact as unsigned.
  assign abs_a = a[31] ? -a : a;
  assign abs_b = b[31] ? -b : b;

  always_comb begin
    rem_sh = {rem[31:0], quo[31]};
    trial  = rem_sh - {1'b0, dvs};
  end

  // NOTE: all state here is assigned with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      q     <= '0;
      r     <= '0;
      div0  <= 1'b0;
      quo   <= '0;
      dvs   <= '0;
      raw_a <= '0;
      rem   <= '0;
      cnt   <= '0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      bz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            quo   <= abs_a;
            dvs   <= abs_b;
            raw_a <= a;
            sq    <= a[31] ^ b[31];
            sr    <= a[31];
            bz    <= (b == 32'd0);
            rem   <= '0;
            cnt   <= 5'd31;
            busy  <= 1'b1;
`ifdef DIVIDER_DIV0_FAST_EN
            state <= (b == 32'd0) ? FIX : CALC;
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          // A negative trial (MSB set) means the divisor did not fit: restore.
          quo <= {quo[30:0], ~trial[32]};
          rem <= trial[32] ? rem_sh : trial;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= FIX;
        end
        FIX: begin
          if (bz) begin
            q    <= 32'hFFFF_FFFF;
            r    <= raw_a;
            div0 <= 1'b1;
          end else begin
            q    <= sq ? -quo : quo;
            r    <= sr ? -rem[31:0] : rem[31:0];
            div0 <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed steps, scoreboard queue of expected results.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] q;
  logic [31:0] r;
  logic        div0;

  divider dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .div0 (div0)
  );

  always #5 clk = ~clk;

`ifdef DIVIDER_DIV0_FAST_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        div0;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tb_);
    exp_t e;
    if (tb_ == 32'd0) begin
      e.q = 32'hFFFF_FFFF; e.r = ta; e.div0 = 1'b1; e.lat = DIV0_LAT;
    end else if (ta == 32'h8000_0000 && tb_ == 32'hFFFF_FFFF) begin
      e.q = ta; e.r = 32'd0; e.div0 = 1'b0; e.lat = 33;
    end else begin
      e.q = $signed(ta) / $signed(tb_);
      e.r = $signed(ta) % $signed(tb_);
      e.div0 = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  // Drive start for one edge (E0); operands are scrambled afterwards.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input bit push);
    if (push) sb.push_back(model(ta, tb_));
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom; b = $urandom;
  endtask

  // Called #1 after E0: waits (bounded) for done, then checks latency, busy span and result.
  task automatic collect(input string tag);
    int   cyc  = 0;
    int   bcnt = busy ? 1 : 0;
    exp_t e;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (done !== 1'b1 && busy === 1'b1) bcnt++;
    end
    chk({tag, ".done"}, done, 1'b1);
    chk({tag, ".busy_at_done"}, busy, 1'b0);
    chk({tag, ".sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, ".latency"}, cyc, e.lat);
      chk({tag, ".busy_cycles"}, bcnt, e.lat);
      chk({tag, ".q"}, q, e.q);
      chk({tag, ".r"}, r, e.r);
      chk({tag, ".div0"}, div0, e.div0);
    end
  endtask

  task automatic no_done(input string tag, input int ncyc);
    int nd = 0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    chk({tag, ".no_done"}, nd, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.q", q, 32'd0);
    chk("reset.r", r, 32'd0);
    chk("reset.div0", div0, 1'b0);
    @(negedge clk) rst = 1'b0;

    issue(32'd100, 32'd7, 1'b1);                  collect("p100_p7");
    repeat (3) @(posedge clk);
    #1;
    chk("hold.q", q, 32'd14);
    chk("hold.r", r, 32'd2);
    chk("hold.done", done, 1'b0);

    // Back-to-back: each issue starts in the cycle done is high.
    issue(32'hFFFF_FF9C, 32'd7, 1'b1);            collect("m100_p7");
    issue(32'd100, 32'hFFFF_FFF9, 1'b1);          collect("p100_m7");
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1);    collect("m100_m7");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);    collect("min_m1");
    issue(32'h8000_0000, 32'd1, 1'b1);            collect("min_p1");
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);    collect("min_min");
    issue(32'h7FFF_FFFF, 32'h8000_0000, 1'b1);    collect("max_min");
    issue(32'd7, 32'd100, 1'b1);                  collect("p7_p100");
    issue(32'd5, 32'd0, 1'b1);                    collect("p5_zero");
    issue(32'hFFFF_FFF7, 32'd0, 1'b1);            collect("m9_zero");
    issue(32'd100, 32'd7, 1'b1);                  collect("div0_clear");

    for (int i = 0; i < 4; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      issue(ra, rb, 1'b1);                        collect("random");
    end

    // Start pulse mid-operation must be ignored.
    issue(32'd100, 32'd7, 1'b1);
    fork
      begin
        repeat (9) @(negedge clk);
        a = 32'd9; b = 32'd3; start = 1'b1;
        @(negedge clk) start = 1'b0;
      end
    join_none
    collect("ignore_start");
    no_done("ignore_start", 40);
    chk("ignore_start.sb_empty", sb.size(), 0);

    // Reset mid-operation aborts without a done pulse.
    issue(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.q", q, 32'd0);
    chk("abort.r", r, 32'd0);
    @(negedge clk) rst = 1'b0;
    no_done("abort", 40);
    issue(32'd9, 32'd3, 1'b1);                    collect("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
